axis_maxpool_out_packer: RTL and testbench

- Sits directly downstream of the maxpool engine's AXI-Stream output.
- Accepts one wide padded beat per handshake: 2*GROUPS*UNITS_EDGES words plus per-word keep and tlast.
- Serializes each beat into OUT_WORDS-wide chunks for the output DMA. Chunks with no kept words are skipped; frame boundaries (tlast) are preserved.

---
 rtl/axis_maxpool_out_packer_if.sv | 15 +
 rtl/axis_maxpool_out_packer.sv | 186 ++++++++++++++++++
 tb/tb_axis_maxpool_out_packer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_maxpool_out_packer_if.sv
// AXI-Stream bundle shared by the maxpool output packer's wide input side
// and its narrow output side. WORDS sets the bus width in words.
interface axis_maxpool_out_packer_if #(
  parameter int WORDS      = 4,
  parameter int WORD_WIDTH = 8
);
  logic                          tvalid;
  logic                          tready;
  logic [WORDS*WORD_WIDTH-1:0]   tdata;
  logic [WORDS-1:0]              tkeep;
  logic                          tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_maxpool_out_packer.sv
// axis_maxpool_out_packer: takes one wide padded beat from the maxpool engine
// and replays it as OUT_WORDS-wide chunks, skipping chunks with no kept words
// and putting tlast on the last emitted chunk of a frame.
// Optional build macro MAXPOOL_OUT_STRIP_PAD_EN: clears keep on the edge-pad
// words of every group before the empty-chunk test.
module axis_maxpool_out_packer #(
  parameter int UNITS        = 8,
  parameter int GROUPS       = 2,
  parameter int KERNEL_H_MAX = 3,
  parameter int WORD_WIDTH   = 8,
  parameter int OUT_WORDS    = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_maxpool_out_packer_if.slave  s_axis,
  axis_maxpool_out_packer_if.master m_axis
);
  localparam int PAD         = KERNEL_H_MAX / 2;
  localparam int UNITS_EDGES = UNITS + KERNEL_H_MAX - 1;
  localparam int IN_WORDS    = 2 * GROUPS * UNITS_EDGES;
  localparam int CHUNKS      = IN_WORDS / OUT_WORDS;
  localparam int CHUNK_W     = OUT_WORDS * WORD_WIDTH;
  localparam int CNT_W       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if ((IN_WORDS % OUT_WORDS) != 0) begin : g_bad_cfg
    $error("axis_maxpool_out_packer: IN_WORDS must be a multiple of OUT_WORDS");
  end

  typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

  state_t                      r_state, w_state_next;
  logic                        r_rdy_en;
  logic [CNT_W-1:0]            r_chunk, w_chunk_next;
  logic [IN_WORDS*WORD_WIDTH-1:0] r_data, w_data_next;
  logic [IN_WORDS-1:0]         r_keep, w_keep_next;
  logic                        r_last, w_last_next;
  logic                        r_m_valid, w_m_valid_next;
  logic [CHUNK_W-1:0]          r_m_data, w_m_data_next;
  logic [OUT_WORDS-1:0]        r_m_keep, w_m_keep_next;
  logic                        r_m_last, w_m_last_next;

  logic [IN_WORDS-1:0]         w_keep_in;
  logic [CHUNK_W-1:0]          w_in_cdata  [CHUNKS];
  logic [CHUNK_W-1:0]          w_reg_cdata [CHUNKS];
  logic [OUT_WORDS-1:0]        w_in_ckeep  [CHUNKS];
  logic [OUT_WORDS-1:0]        w_reg_ckeep [CHUNKS];
  logic [CHUNKS-1:0]           w_in_ne, w_reg_ne;
  logic                        w_in_found, w_in_more, w_reg_found, w_reg_more;
  logic [CNT_W-1:0]            w_in_idx, w_reg_idx;
  logic                        w_out_hs, w_final, w_in_hs;

`ifdef MAXPOOL_OUT_STRIP_PAD_EN
  // Pad words sit at unit positions below PAD or at/above UNITS+PAD in each group.
  logic [IN_WORDS-1:0] w_pad_mask;
  for (genvar gi = 0; gi < IN_WORDS; gi++) begin : g_pad
    localparam int U = gi % UNITS_EDGES;
    assign w_pad_mask[gi] = (U >= PAD) && (U < UNITS + PAD);
  end
  assign w_keep_in = s_axis.tkeep & w_pad_mask;
`else
  assign w_keep_in = s_axis.tkeep;
`endif

  // Chunk views of the incoming beat and of the latched beat.
  for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
    assign w_in_cdata[gi]  = s_axis.tdata[gi*CHUNK_W +: CHUNK_W];
    assign w_in_ckeep[gi]  = w_keep_in[gi*OUT_WORDS +: OUT_WORDS];
    assign w_in_ne[gi]     = |w_in_ckeep[gi];
    assign w_reg_cdata[gi] = r_data[gi*CHUNK_W +: CHUNK_W];
    assign w_reg_ckeep[gi] = r_keep[gi*OUT_WORDS +: OUT_WORDS];
    assign w_reg_ne[gi]    = |w_reg_ckeep[gi];
  end

  // Priority search: lowest non-empty chunk of a new beat, and the next
  // non-empty chunk above the current one; *_more flags a later non-empty chunk.
  always_comb begin
    w_in_found  = 1'b0;
    w_in_idx    = '0;
    w_in_more   = 1'b0;
    w_reg_found = 1'b0;
    w_reg_idx   = '0;
    w_reg_more  = 1'b0;
    for (int k = CHUNKS - 1; k >= 0; k--) begin
      if (w_in_ne[k]) begin
        w_in_found = 1'b1;
        w_in_idx   = CNT_W'(k);
      end
      if (w_reg_ne[k] && (k > int'(r_chunk))) begin
        w_reg_found = 1'b1;
        w_reg_idx   = CNT_W'(k);
      end
    end
    for (int k = 0; k < CHUNKS; k++) begin
      if (w_in_ne[k] && (k > int'(w_in_idx)))   w_in_more  = 1'b1;
      if (w_reg_ne[k] && (k > int'(w_reg_idx))) w_reg_more = 1'b1;
    end
  end

  // The final chunk leaving frees the input side in the same cycle, so a new
  // beat can follow without a bubble (tready depends combinationally on m tready).
  assign w_out_hs      = r_m_valid & m_axis.tready;
  assign w_final       = (r_state == ST_SEND) & w_out_hs & ~w_reg_found;
  assign s_axis.tready = r_rdy_en & ((r_state == ST_IDLE) | w_final);
  assign w_in_hs       = s_axis.tvalid & s_axis.tready;

  // Next-state and next-output selection.
  always_comb begin
    w_state_next   = r_state;
    w_chunk_next   = r_chunk;
    w_data_next    = r_data;
    w_keep_next    = r_keep;
    w_last_next    = r_last;
    w_m_valid_next = r_m_valid;
    w_m_data_next  = r_m_data;
    w_m_keep_next  = r_m_keep;
    w_m_last_next  = r_m_last;
    if (w_in_hs) begin
      w_data_next = s_axis.tdata;
      w_keep_next = w_keep_in;
      w_last_next = s_axis.tlast;
      if (w_in_found) begin
        w_state_next   = ST_SEND;
        w_chunk_next   = w_in_idx;
        w_m_valid_next = 1'b1;
        w_m_data_next  = w_in_cdata[w_in_idx];
        w_m_keep_next  = w_in_ckeep[w_in_idx];
        w_m_last_next  = s_axis.tlast & ~w_in_more;
      end else if (s_axis.tlast) begin
        // Nothing kept but the frame must still close: one empty tlast chunk.
        w_state_next   = ST_SEND;
        w_chunk_next   = '0;
        w_m_valid_next = 1'b1;
        w_m_data_next  = '0;
        w_m_keep_next  = '0;
        w_m_last_next  = 1'b1;
      end else begin
        w_state_next   = ST_IDLE;
        w_m_valid_next = 1'b0;
      end
    end else if (w_out_hs && w_reg_found) begin
      w_chunk_next  = w_reg_idx;
      w_m_data_next = w_reg_cdata[w_reg_idx];
      w_m_keep_next = w_reg_ckeep[w_reg_idx];
      w_m_last_next = r_last & ~w_reg_more;
    end else if (w_final) begin
      w_state_next   = ST_IDLE;
      w_m_valid_next = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Latched beat, chunk pointer and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdy_en  <= 1'b0;
      r_chunk   <= '0;
      r_data    <= '0;
      r_keep    <= '0;
      r_last    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_rdy_en  <= 1'b1;
      r_chunk   <= w_chunk_next;
      r_data    <= w_data_next;
      r_keep    <= w_keep_next;
      r_last    <= w_last_next;
      r_m_valid <= w_m_valid_next;
      r_m_data  <= w_m_data_next;
      r_m_keep  <= w_m_keep_next;
      r_m_last  <= w_m_last_next;
    end
  end

  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tlast  = r_m_last;
endmodule

// File: tb/tb_axis_maxpool_out_packer.sv
// Directed bench for axis_maxpool_out_packer with default parameters
// (40-word input beats, 4-word output chunks, 10 chunks per beat).
module tb_axis_maxpool_out_packer;
  localparam int IN_WORDS  = 40;
  localparam int OUT_WORDS = 4;
  localparam int WW        = 8;
  localparam int CHUNKS    = 10;
`ifdef MAXPOOL_OUT_STRIP_PAD_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  axis_maxpool_out_packer_if #(.WORDS(IN_WORDS),  .WORD_WIDTH(WW)) s_if ();
  axis_maxpool_out_packer_if #(.WORDS(OUT_WORDS), .WORD_WIDTH(WW)) m_if ();

  axis_maxpool_out_packer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis  (m_if)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Downstream ready: mode 0 always ready, mode 1 alternates every cycle.
  int   rdy_mode  = 0;
  logic rdy_phase = 1'b0;
  always @(posedge aclk) begin
    #1;
    if (rdy_mode == 0) m_if.tready = 1'b1;
    else begin
      m_if.tready = rdy_phase;
      rdy_phase   = ~rdy_phase;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Keep per chunk of a full-keep beat once the pad words are stripped.
  logic [3:0] strip_keep [CHUNKS] = '{4'hE, 4'hF, 4'h9, 4'hF, 4'h7,
                                      4'hE, 4'hF, 4'h9, 4'hF, 4'h7};

  // Output monitor: records every chunk handshake and checks stall stability.
  logic [31:0] q_data [$];
  logic [3:0]  q_keep [$];
  logic        q_last [$];
  logic        q_srdy [$];
  int          q_cyc  [$];
  logic [37:0] prev_out   = '0;
  logic        prev_stall = 1'b0;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (prev_stall)
        check("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}, prev_out);
      if (m_if.tvalid && m_if.tready) begin
        q_data.push_back(m_if.tdata);
        q_keep.push_back(m_if.tkeep);
        q_last.push_back(m_if.tlast);
        q_srdy.push_back(s_if.tready);
        q_cyc.push_back(cyc);
        $display("out cyc=%0d data=%h keep=%h last=%0d", cyc, m_if.tdata, m_if.tkeep, m_if.tlast);
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_out   = {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic clear_q();
    q_data.delete(); q_keep.delete(); q_last.delete(); q_srdy.delete(); q_cyc.delete();
  endtask

  // Offer one beat until accepted; acc = cycle number in which chunk 0 can appear.
  task automatic send_beat(input string tag, input logic [IN_WORDS*WW-1:0] data,
                           input logic [IN_WORDS-1:0] keep, input logic last, output int acc);
    s_if.tdata  = data;
    s_if.tkeep  = keep;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (s_if.tready === 1'b1) begin
        step();
        acc = cyc;
        break;
      end
      step();
    end
    s_if.tvalid = 1'b0;
    check({tag, "_accepted"}, (acc >= 0), 1'b1);
    $display("in  %s accepted cyc=%0d keep=%h last=%0d", tag, acc, keep, last);
  endtask

  task automatic wait_chunks(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) step();
    repeat (4) step();
    check({tag, "_count"}, q_data.size(), n);
  endtask

  task automatic check_beat(input string tag, input int first, input logic [IN_WORDS*WW-1:0] data,
                            input logic last, input int acc, input bit timed);
    for (int k = 0; k < CHUNKS; k++) begin
      int idx = first + k;
      if (idx < q_data.size()) begin
        check($sformatf("%s_data%0d", tag, k), q_data[idx], data[k*32 +: 32]);
        check($sformatf("%s_keep%0d", tag, k), q_keep[idx], STRIP ? strip_keep[k] : 4'hF);
        check($sformatf("%s_last%0d", tag, k), q_last[idx], last && (k == CHUNKS - 1));
        if (timed) check($sformatf("%s_cyc%0d", tag, k), q_cyc[idx], acc + k);
      end
    end
  endtask

  logic [IN_WORDS*WW-1:0] full_a, full_b, full_c, sparse;
  int acc, acc1, acc2;

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    for (int w = 0; w < IN_WORDS; w++) begin
      full_a[w*WW +: WW] = 8'(w);
      full_b[w*WW +: WW] = 8'(w + 50);
      full_c[w*WW +: WW] = 8'(255 - w);
      sparse[w*WW +: WW] = 8'(w + 100);
    end

    // Reset held for three cycles.
    repeat (3) step();
    check("rst_tvalid", m_if.tvalid, 1'b0);
    check("rst_tkeep",  m_if.tkeep,  4'h0);
    check("rst_tlast",  m_if.tlast,  1'b0);
    check("rst_tdata",  m_if.tdata,  32'h0);
    aresetn = 1'b1;
    step();
    check("rst_s_tready", s_if.tready, 1'b1);

    // Full beat, always ready: ten chunks on consecutive cycles.
    clear_q();
    send_beat("full", full_a, '1, 1'b1, acc);
    wait_chunks("full", 10, 40);
    check_beat("full", 0, full_a, 1'b1, acc, 1'b1);
    if (q_srdy.size() >= 10) begin
      check("full_srdy_c8", q_srdy[8], 1'b0);
      check("full_srdy_c9", q_srdy[9], 1'b1);
    end

    // Sparse beat: only words 0 and 39 kept (both are pad words when stripping).
    clear_q();
    send_beat("sparse", sparse, 40'h80_0000_0001, 1'b0, acc);
    wait_chunks("sparse", STRIP ? 0 : 2, 20);
    if (q_data.size() > 0) begin
      check("sparse_data0", q_data[0], {8'd103, 8'd102, 8'd101, 8'd100});
      check("sparse_keep0", q_keep[0], 4'b0001);
      check("sparse_last0", q_last[0], 1'b0);
      check("sparse_cyc0",  q_cyc[0],  acc);
    end
    if (q_data.size() > 1) begin
      check("sparse_data1", q_data[1], {8'd139, 8'd138, 8'd137, 8'd136});
      check("sparse_keep1", q_keep[1], 4'b1000);
      check("sparse_last1", q_last[1], 1'b0);
      check("sparse_cyc1",  q_cyc[1],  acc + 1);
    end

    // Empty beat without tlast: swallowed.
    clear_q();
    send_beat("empty", full_a, '0, 1'b0, acc);
    wait_chunks("empty", 0, 0);

    // Empty beat with tlast: one zero chunk that closes the frame.
    clear_q();
    send_beat("empty_last", full_a, '0, 1'b1, acc);
    wait_chunks("empty_last", 1, 10);
    if (q_data.size() > 0) begin
      check("empty_last_data", q_data[0], 32'h0);
      check("empty_last_keep", q_keep[0], 4'h0);
      check("empty_last_last", q_last[0], 1'b1);
      check("empty_last_cyc",  q_cyc[0],  acc);
    end

    // Backpressure: alternating ready, second beat waits for chunk 9.
    rdy_mode = 1;
    clear_q();
    send_beat("bp1", full_b, '1, 1'b1, acc1);
    send_beat("bp2", full_c, '1, 1'b0, acc2);
    wait_chunks("bp", 20, 100);
    check_beat("bp1", 0,  full_b, 1'b1, acc1, 1'b0);
    check_beat("bp2", 10, full_c, 1'b0, acc2, 1'b0);
    if (q_cyc.size() >= 10) check("bp2_accept_cyc", acc2, q_cyc[9] + 1);
    rdy_mode = 0;
    repeat (2) step();

    // Reset in the middle of a frame, right after chunk 5 handshakes.
    clear_q();
    send_beat("pre_rst", full_a, '1, 1'b1, acc);
    for (int i = 0; i < 30 && q_data.size() < 6; i++) step();
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", m_if.tvalid, 1'b0);
    check("midrst_tkeep",  m_if.tkeep,  4'h0);
    check("midrst_tlast",  m_if.tlast,  1'b0);
    check("midrst_count",  q_data.size(), 6);
    step();
    step();
    aresetn = 1'b1;
    step();
    check("post_rst_quiet", q_data.size(), 6);
    clear_q();
    send_beat("post_rst", full_a, '1, 1'b1, acc);
    wait_chunks("post_rst", 10, 40);
    check_beat("post_rst", 0, full_a, 1'b1, acc, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
